// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM states, port indices,
// default bus widths and the strobe-length counter helper.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbStateT;

  localparam bit PORT_CORE = 1'b0;
  localparam bit PORT_DMA  = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Strobe length counter holds RAM_LAT-1, RAM_LAT being at most 15.
  localparam int LAT_CNT_W = 4;

  function automatic logic [LAT_CNT_W-1:0] latInit(input int ramLat);
    return LAT_CNT_W'(ramLat - 1);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Request/response bundle for both requesters plus the RAM side of the arbiter.
// slave  : the arbiter's view (takes requests, drives the RAM).
// master : the surrounding system's view (requesters and the RAM itself).
interface ram_arbiter_if #(
  parameter int ADDR_W = cpu_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W = cpu_mem_pkg::DEF_DATA_W
);

  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, req0_done, req0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata,
    output ram_addr, ram_wdata, ram_read, ram_write,
    input  ram_rdata
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, req0_done, req0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata,
    input  ram_addr, ram_wdata, ram_read, ram_write,
    output ram_rdata
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way grant.
// Default build: round robin, the port that did not win last time takes a tie.
// With ARB_FIXED_PRIO_EN defined: the Core port always takes a tie.
module rr_arb2
  import cpu_mem_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       lastGrant,
  output logic       grantValid,
  output logic       grantIdx
);

`ifdef ARB_FIXED_PRIO_EN
  logic unusedLastGrant;
  assign unusedLastGrant = lastGrant;
`endif

  // Pick the winner among the currently valid ports.
  always_comb begin
    grantValid = |valid;
    grantIdx   = PORT_CORE;
`ifdef ARB_FIXED_PRIO_EN
    if (!valid[PORT_CORE] && valid[PORT_DMA]) grantIdx = PORT_DMA;
`else
    if (valid == 2'b11)      grantIdx = ~lastGrant;
    else if (valid[PORT_DMA]) grantIdx = PORT_DMA;
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between the Core (port 0)
// and the DMA/program loader (port 1). One access at a time; the RAM
// strobe is held RAM_LAT cycles, then a one-cycle done pulse is returned.
// Optional build macro: ARB_FIXED_PRIO_EN (Core wins ties, see rr_arb2).
//
// state  | meaning
// IDLE   | waiting for a request; winner sees ready this cycle
// ACCESS | strobe held on the RAM, counting down the access length
// RESP   | done pulse to the granted port, strobes low
module ram_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RAM_LAT = 1
) (
  input  logic           Clk,
  input  logic           Reset_n,
  ram_arbiter_if.slave   bus
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = latInit(RAM_LAT);

  arbStateT             stateQ;
  arbStateT             stateD;

  logic [1:0]           validVec;
  logic                 winValid;
  logic                 winIdx;
  logic                 winWrite;
  logic [ADDR_W-1:0]    winAddr;
  logic [DATA_W-1:0]    winWdata;
  logic                 accept;
  logic [1:0]           readyVec;

  logic                 lastGrantQ;
  logic                 grantQ;
  logic                 wrQ;
  logic [ADDR_W-1:0]    addrQ;
  logic [DATA_W-1:0]    wdataQ;
  logic [LAT_CNT_W-1:0] latCntQ;
  logic                 ramReadQ;
  logic                 ramWriteQ;
  logic [1:0]           doneQ;
  logic [DATA_W-1:0]    rdata0Q;
  logic [DATA_W-1:0]    rdata1Q;

  assign validVec = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .valid      (validVec),
    .lastGrant  (lastGrantQ),
    .grantValid (winValid),
    .grantIdx   (winIdx)
  );

  assign winWrite = (winIdx == PORT_DMA) ? bus.req1_write : bus.req0_write;
  assign winAddr  = (winIdx == PORT_DMA) ? bus.req1_addr  : bus.req0_addr;
  assign winWdata = (winIdx == PORT_DMA) ? bus.req1_wdata : bus.req0_wdata;

  // State register; reset drops any transaction in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) stateQ <= IDLE;
    else          stateQ <= stateD;
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (winValid) stateD = ACCESS;
      ACCESS:  if (latCntQ == '0) stateD = RESP;
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Ready is only ever offered from IDLE, so accesses never overlap.
  always_comb begin
    accept   = 1'b0;
    readyVec = 2'b00;
    if (stateQ == IDLE && winValid) begin
      accept           = 1'b1;
      readyVec[winIdx] = 1'b1;
    end
  end

  // Request capture, strobe generation, countdown, read data and done pulse.
  // Strobes come straight from flops so the RAM never sees a glitch.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lastGrantQ <= PORT_DMA;
      grantQ     <= PORT_CORE;
      wrQ        <= 1'b0;
      addrQ      <= '0;
      wdataQ     <= '0;
      latCntQ    <= '0;
      ramReadQ   <= 1'b0;
      ramWriteQ  <= 1'b0;
      doneQ      <= 2'b00;
      rdata0Q    <= '0;
      rdata1Q    <= '0;
    end else begin
      doneQ <= 2'b00;
      case (stateQ)
        IDLE: begin
          if (accept) begin
            wrQ        <= winWrite;
            addrQ      <= winAddr;
            wdataQ     <= winWdata;
            grantQ     <= winIdx;
            lastGrantQ <= winIdx;
            latCntQ    <= LAT_INIT;
            ramReadQ   <= ~winWrite;
            ramWriteQ  <= winWrite;
          end
        end
        ACCESS: begin
          if (latCntQ == '0) begin
            ramReadQ  <= 1'b0;
            ramWriteQ <= 1'b0;
            if (grantQ == PORT_DMA) begin
              doneQ[PORT_DMA] <= 1'b1;
              if (!wrQ) rdata1Q <= bus.ram_rdata;
            end else begin
              doneQ[PORT_CORE] <= 1'b1;
              if (!wrQ) rdata0Q <= bus.ram_rdata;
            end
          end else begin
            latCntQ <= latCntQ - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = readyVec[PORT_CORE];
  assign bus.req1_ready = readyVec[PORT_DMA];
  assign bus.req0_done  = doneQ[PORT_CORE];
  assign bus.req1_done  = doneQ[PORT_DMA];
  assign bus.req0_rdata = rdata0Q;
  assign bus.req1_rdata = rdata1Q;
  assign bus.ram_addr   = addrQ;
  assign bus.ram_wdata  = wdataQ;
  assign bus.ram_read   = ramReadQ;
  assign bus.ram_write  = ramWriteQ;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM_LAT=3 instance carries most tests, a RAM_LAT=1
// instance covers the single-write timing. Honors ARB_FIXED_PRIO_EN.
module tb_ram_arbiter;

  localparam int LAT3     = 3;
  localparam int RAND_CYC = 10000;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();
  ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(b3));
  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(b1));

  // Simple RAM behind the LAT3 instance, with a bench preload path.
  bit [31:0]  mem3 [256];
  logic       preEn = 1'b0;
  logic [7:0] preAddr = '0;
  logic [31:0] preData = '0;
  always @(posedge Clk) begin
    if (preEn) mem3[preAddr] <= preData;
    else if (b3.ram_write) mem3[b3.ram_addr[7:0]] <= b3.ram_wdata;
  end
  assign b3.ram_rdata = mem3[b3.ram_addr[7:0]];
  assign b1.ram_rdata = 32'h0BAD_F00D;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clearInputs();
    b3.req0_valid = 0; b3.req0_write = 0; b3.req0_addr = '0; b3.req0_wdata = '0;
    b3.req1_valid = 0; b3.req1_write = 0; b3.req1_addr = '0; b3.req1_wdata = '0;
    b1.req0_valid = 0; b1.req0_write = 0; b1.req0_addr = '0; b1.req0_wdata = '0;
    b1.req1_valid = 0; b1.req1_write = 0; b1.req1_addr = '0; b1.req1_wdata = '0;
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    clearInputs();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  typedef struct {
    bit       v0, v1, w0, w1;
    bit [1:0] expReady;   // {ready1, ready0}
    bit       expRd, expWr;
  } vecT;

  vecT vecs [6];

  // random-phase model state
  bit        vld [2];
  bit        wrr [2];
  logic [31:0] adr [2];
  logic [31:0] wdt [2];
  bit        accPrev [2];
  bit [31:0] memModel [256];
  logic [31:0] rdExp [2];

  initial begin
    int rdCnt, firstRd, lastRd, doneAt, busyRdy, doneCnt, got;
    logic [31:0] rdAtDone;
    logic [1:0] grants [4];
    logic [1:0] expGrant [4];
    int accCyc, nextIdle, accepted, doneSeen;
    bit curPort, curWr, lastG, win, eR0, eR1, eRd, eWr, eD0, eD1;
    logic [31:0] curAddr, curWdata;

    // arbitration vectors applied from IDLE, in sequence after a reset
    vecs[0] = '{1, 0, 0, 0, 2'b01, 1, 0};
    vecs[1] = '{0, 1, 0, 1, 2'b10, 0, 1};
    vecs[2] = '{1, 1, 1, 0, 2'b01, 0, 1};
    vecs[3] = FIXED ? '{1, 1, 1, 0, 2'b01, 0, 1} : '{1, 1, 1, 0, 2'b10, 1, 0};
    vecs[4] = '{0, 0, 0, 0, 2'b00, 0, 0};
    vecs[5] = '{1, 1, 0, 1, 2'b01, 1, 0};

    clearInputs();
    repeat (2) @(negedge Clk);
    chk("reset ctl lat3", {b3.req1_ready, b3.req0_ready, b3.ram_read, b3.ram_write,
                           b3.req1_done, b3.req0_done}, 0);
    chk("reset ram bus lat3", {b3.ram_addr, b3.ram_wdata}, 0);
    chk("reset rdata lat3", {b3.req1_rdata, b3.req0_rdata}, 0);
    chk("reset ctl lat1", {b1.req1_ready, b1.req0_ready, b1.ram_read, b1.ram_write,
                           b1.req1_done, b1.req0_done}, 0);
    Reset_n = 1'b1;

    // single write, RAM_LAT = 1
    @(posedge Clk); #1;
    b1.req0_valid = 1; b1.req0_write = 1; b1.req0_addr = 32'h10; b1.req0_wdata = 32'hDEADBEEF;
    @(negedge Clk);
    chk("write ready T", {b1.req1_ready, b1.req0_ready}, 2'b01);
    @(posedge Clk); #1;
    b1.req0_valid = 0;
    @(negedge Clk);
    chk("write strobe T+1", {b1.ram_read, b1.ram_write, b1.req1_done, b1.req0_done}, 4'b0100);
    chk("write addr/data T+1", {b1.ram_addr, b1.ram_wdata}, {32'h10, 32'hDEADBEEF});
    @(negedge Clk);
    chk("write done T+2", {b1.ram_read, b1.ram_write, b1.req1_done, b1.req0_done}, 4'b0001);
    chk("write rdata0 unchanged", b1.req0_rdata, 0);
    @(negedge Clk);
    chk("write done one pulse", {b1.req1_done, b1.req0_done}, 0);

    // single read, RAM_LAT = 3
    @(posedge Clk); #1;
    preEn = 1; preAddr = 8'h10; preData = 32'hDEADBEEF;
    @(posedge Clk); #1;
    preEn = 0;
    b3.req1_valid = 1; b3.req1_write = 0; b3.req1_addr = 32'h10;
    @(negedge Clk);
    chk("read ready T", {b3.req1_ready, b3.req0_ready}, 2'b10);
    rdCnt = 0; firstRd = -1; lastRd = -1; doneAt = -1; rdAtDone = '0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge Clk); #1;
      b3.req1_valid = 0;
      @(negedge Clk);
      if (b3.ram_read) begin
        rdCnt++;
        if (firstRd < 0) firstRd = k;
        lastRd = k;
      end
      if (b3.req1_done) begin
        doneAt = k;
        rdAtDone = b3.req1_rdata;
      end
    end
    chk("read strobe count", rdCnt, 3);
    chk("read strobe first", firstRd, 1);
    chk("read strobe last", lastRd, 3);
    chk("read done cycle", doneAt, 4);
    chk("read rdata1", rdAtDone, 32'hDEADBEEF);

    // table-driven arbitration
    doReset();
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      b3.req0_valid = vecs[i].v0; b3.req0_write = vecs[i].w0; b3.req0_addr = 32'h20 + i;
      b3.req1_valid = vecs[i].v1; b3.req1_write = vecs[i].w1; b3.req1_addr = 32'h40 + i;
      b3.req0_wdata = $urandom; b3.req1_wdata = $urandom;
      @(negedge Clk);
      chk($sformatf("vec%0d ready", i), {b3.req1_ready, b3.req0_ready}, vecs[i].expReady);
      @(posedge Clk); #1;
      b3.req0_valid = 0; b3.req1_valid = 0;
      @(negedge Clk);
      chk($sformatf("vec%0d strobes", i), {b3.ram_read, b3.ram_write}, {vecs[i].expRd, vecs[i].expWr});
      repeat (LAT3 + 1) @(posedge Clk);
    end

    // contention: both valid continuously
    doReset();
    for (int i = 0; i < 4; i++) begin
      grants[i] = 2'b00;
      expGrant[i] = (FIXED || (i % 2 == 0)) ? 2'b01 : 2'b10;
    end
    @(posedge Clk); #1;
    b3.req0_valid = 1; b3.req0_write = 1; b3.req0_addr = 32'h30;
    b3.req1_valid = 1; b3.req1_write = 1; b3.req1_addr = 32'h31;
    got = 0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge Clk);
      if (b3.req0_ready || b3.req1_ready) begin
        grants[got] = {b3.req1_ready, b3.req0_ready};
        got++;
      end
      @(posedge Clk); #1;
    end
    b3.req0_valid = 0; b3.req1_valid = 0;
    chk("contention grant count", got, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("contention grant%0d", i), grants[i], expGrant[i]);
    repeat (6) @(posedge Clk);

    // busy blocking: port 1 arrives during port 0's access
    doReset();
    @(posedge Clk); #1;
    b3.req0_valid = 1; b3.req0_write = 0; b3.req0_addr = 32'h10;
    @(negedge Clk);
    chk("busy ready0 T", {b3.req1_ready, b3.req0_ready}, 2'b01);
    @(posedge Clk); #1;
    b3.req0_valid = 0;
    b3.req1_valid = 1; b3.req1_write = 0; b3.req1_addr = 32'h11;
    busyRdy = 0;
    for (int k = 1; k <= LAT3 + 1; k++) begin
      @(negedge Clk);
      busyRdy += int'(b3.req1_ready);
      @(posedge Clk); #1;
    end
    chk("busy ready1 blocked", busyRdy, 0);
    @(negedge Clk);
    chk("busy ready1 after idle", {b3.req1_ready, b3.req0_ready}, 2'b10);
    @(posedge Clk); #1;
    b3.req1_valid = 0;
    repeat (6) @(posedge Clk);

    // reset in the middle of a read access
    doReset();
    @(posedge Clk); #1;
    b3.req0_valid = 1; b3.req0_write = 0; b3.req0_addr = 32'h10;
    @(posedge Clk); #1;
    b3.req0_valid = 0;
    @(posedge Clk); #1;
    chk("midreset strobe before", b3.ram_read, 1);
    Reset_n = 1'b0;
    #1;
    chk("midreset strobe async drop", b3.ram_read, 0);
    doneCnt = 0;
    repeat (2) begin
      @(negedge Clk);
      doneCnt += int'(b3.req0_done) + int'(b3.req1_done);
    end
    Reset_n = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      doneCnt += int'(b3.req0_done) + int'(b3.req1_done);
    end
    chk("midreset no done", doneCnt, 0);
    @(posedge Clk); #1;
    b3.req0_valid = 1; b3.req0_write = 1; b3.req0_addr = 32'h12; b3.req0_wdata = 32'h5A5A_0001;
    @(negedge Clk);
    chk("midreset fresh ready0", {b3.req1_ready, b3.req0_ready}, 2'b01);
    @(posedge Clk); #1;
    b3.req0_valid = 0;
    repeat (LAT3 + 1) @(negedge Clk);
    chk("midreset fresh done0", {b3.req1_done, b3.req0_done}, 2'b01);

    // randomized traffic against a transaction-level model
    doReset();
    accCyc = -100; nextIdle = 0; accepted = 0; doneSeen = 0; lastG = 1'b1;
    curPort = 0; curWr = 0; curAddr = '0; curWdata = '0;
    rdExp[0] = '0; rdExp[1] = '0;
    for (int p = 0; p < 2; p++) begin
      vld[p] = 0; wrr[p] = 0; adr[p] = '0; wdt[p] = '0; accPrev[p] = 0;
    end
    for (int cyc = 0; cyc < RAND_CYC + 20; cyc++) begin
      @(posedge Clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (cyc >= RAND_CYC) vld[p] = 0;
        else if (!vld[p] || accPrev[p]) begin
          vld[p] = ($urandom_range(0, 1) == 1);
          wrr[p] = ($urandom_range(0, 1) == 1);
          adr[p] = 32'h80 + 32'($urandom_range(0, 127));
          wdt[p] = $urandom;
        end else if ($urandom_range(0, 15) == 0) vld[p] = 0;
        accPrev[p] = 0;
      end
      b3.req0_valid = vld[0]; b3.req0_write = wrr[0]; b3.req0_addr = adr[0]; b3.req0_wdata = wdt[0];
      b3.req1_valid = vld[1]; b3.req1_write = wrr[1]; b3.req1_addr = adr[1]; b3.req1_wdata = wdt[1];
      @(negedge Clk);

      if (cyc == accCyc + LAT3 + 1 && !curWr) rdExp[curPort] = memModel[curAddr[7:0]];
      eR0 = 0; eR1 = 0; eRd = 0; eWr = 0; eD0 = 0; eD1 = 0; win = 0;
      if (cyc > accCyc && cyc <= accCyc + LAT3) begin
        eRd = !curWr; eWr = curWr;
      end
      if (cyc == accCyc + LAT3 + 1) begin
        if (curPort) eD1 = 1; else eD0 = 1;
      end
      if (cyc >= nextIdle && (vld[0] || vld[1])) begin
        if (vld[0] && vld[1]) win = FIXED ? 1'b0 : !lastG;
        else win = vld[1];
        if (win) eR1 = 1; else eR0 = 1;
      end

      chk("rand ctl", {b3.req1_ready, b3.req0_ready, b3.ram_read, b3.ram_write,
                       b3.req1_done, b3.req0_done}, {eR1, eR0, eRd, eWr, eD1, eD0});
      chk("rand strobe excl", b3.ram_read & b3.ram_write, 0);
      if (eRd || eWr) chk("rand ram addr/wdata", {b3.ram_addr, b3.ram_wdata}, {curAddr, curWdata});
      chk("rand rdata", {b3.req1_rdata, b3.req0_rdata}, {rdExp[1], rdExp[0]});
      doneSeen += int'(b3.req0_done) + int'(b3.req1_done);

      if (eR0 || eR1) begin
        accCyc = cyc; nextIdle = cyc + LAT3 + 2;
        curPort = win; curWr = wrr[win]; curAddr = adr[win]; curWdata = wdt[win];
        lastG = win;
        if (curWr) memModel[curAddr[7:0]] = curWdata;
        accepted++;
        accPrev[win] = 1;
      end
    end
    chk("rand one done per accept", doneSeen, accepted);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
